// File: rtl/mux21_rr_feeder_pick.sv
// rr_pick2 -- combinational two-way round-robin winner.
//
// Ports:
//   i_v0, i_v1 : request valids from source 0 / source 1
//   i_last     : source granted in the most recent contest
//   o_win      : winning source (only meaningful when o_any=1)
//   o_any      : at least one source is requesting
module rr_pick2 (
    input  logic i_v0,
    input  logic i_v1,
    input  logic i_last,
    output logic o_win,
    output logic o_any
);

    // On contention the source not granted last time wins.
    // With a single requester, that requester wins.
    assign o_win = (i_v0 & i_v1) ? ~i_last : i_v1;
    assign o_any = i_v0 | i_v1;

endmodule

// File: rtl/mux21_rr_feeder.sv
// mux21_rr_feeder -- two-input round-robin arbiter with a one-entry
// registered output stage, feeding the select of a downstream mux21.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   d0/d0_valid/d0_ready  : source 0 stream (W bits)
//   d1/d1_valid/d1_ready  : source 1 stream (W bits)
//   s                     : source of the datum held on y (mux21 select)
//   y/y_valid/y_ready     : registered output stream
//   cnt0, cnt1            : saturating per-source accepted-transfer counts
module mux21_rr_feeder #(
    parameter int W     = 1,
    parameter int CW    = 8,
    parameter int FIRST = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  d0,
    input  logic          d0_valid,
    output logic          d0_ready,
    input  logic [W-1:0]  d1,
    input  logic          d1_valid,
    output logic          d1_ready,
    output logic          s,
    output logic [W-1:0]  y,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_FULL   = 1'b1;
    localparam logic       FIRST_SRC = (FIRST != 0);

    logic [0:0]    r_state;
    logic [W-1:0]  r_y;
    logic          r_s;
    logic          r_last;
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;

    logic w_win;
    logic w_any;
    logic w_ld;
    logic w_acc;

    rr_pick2 u_pick (
        .i_v0   (d0_valid),
        .i_v1   (d1_valid),
        .i_last (r_last),
        .o_win  (w_win),
        .o_any  (w_any)
    );

    // Load when empty or when the held datum leaves this cycle, so a drain
    // and a refill can share one edge.
    assign w_ld  = (r_state == ST_EMPTY) | y_ready;
    assign w_acc = w_ld & w_any & ~rst;

    assign d0_ready = w_acc & ~w_win;
    assign d1_ready = w_acc &  w_win;

    assign y       = r_y;
    assign s       = r_s;
    assign y_valid = (r_state == ST_FULL);
    assign cnt0    = r_cnt0;
    assign cnt1    = r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_y     <= '0;
            r_s     <= 1'b0;
            // Pointer records the "last" winner, so the opposite of FIRST
            // makes FIRST win the first contest.
            r_last  <= ~FIRST_SRC;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else if (w_acc) begin
            r_state <= ST_FULL;
            r_y     <= w_win ? d1 : d0;
            r_s     <= w_win;
            r_last  <= w_win;
            if (!w_win && (r_cnt0 != {CW{1'b1}}))
                r_cnt0 <= r_cnt0 + CW'(1);
            if (w_win && (r_cnt1 != {CW{1'b1}}))
                r_cnt1 <= r_cnt1 + CW'(1);
        end else if (y_ready) begin
            // Drained with nothing to refill; y and s keep their values.
            r_state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_mux21_rr_feeder.sv
module tb_mux21_rr_feeder;

    localparam int W  = 1;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  d0, d1, y;
    logic          d0_valid, d1_valid, d0_ready, d1_ready;
    logic          s, y_valid, y_ready;
    logic [CW-1:0] cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    mux21_rr_feeder #(.W(W), .CW(CW), .FIRST(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .d0       (d0),
        .d0_valid (d0_valid),
        .d0_ready (d0_ready),
        .d1       (d1),
        .d1_valid (d1_valid),
        .d1_ready (d1_ready),
        .s        (s),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d0 = '0; d1 = '0; d0_valid = 0; d1_valid = 0; y_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        rst = 1;
        idle_inputs();

        // Reset then idle
        do_reset();
        chk("rst_yv",   y_valid, 0);
        chk("rst_s",    s, 0);
        chk("rst_y",    y, 0);
        chk("rst_c0",   cnt0, 0);
        chk("rst_c1",   cnt1, 0);
        chk("rst_r0",   d0_ready, 0);
        chk("rst_r1",   d1_ready, 0);

        // Readies forced low while rst is high
        rst = 1; d0_valid = 1; d1_valid = 1; y_ready = 1; #1;
        chk("inrst_r0", d0_ready, 0);
        chk("inrst_r1", d1_ready, 0);

        // Single source, downstream always ready: d0 = 1,0,1
        do_reset();
        d0_valid = 1; y_ready = 1;
        pat = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            d0 = pat[i]; #1;
            chk("ss_r0", d0_ready, 1);
            chk("ss_r1", d1_ready, 0);
            tick();
            chk("ss_y",  y, pat[i]);
            chk("ss_s",  s, 0);
            chk("ss_yv", y_valid, 1);
        end
        d0_valid = 0; tick();
        chk("ss_drain_yv", y_valid, 0);
        chk("ss_hold_y",   y, 1);
        chk("ss_c0",       cnt0, 3);
        chk("ss_c1",       cnt1, 0);

        // Contention, FIRST=0: grants alternate 0,1,0,1
        do_reset();
        d0 = 0; d1 = 1; d0_valid = 1; d1_valid = 1; y_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ct_r0", d0_ready, (i % 2 == 0));
            chk("ct_r1", d1_ready, (i % 2 == 1));
            tick();
            chk("ct_s", s, (i % 2 == 1));
            chk("ct_y", y, (i % 2 == 1));
        end
        chk("ct_c0", cnt0, 2);
        chk("ct_c1", cnt1, 2);

        // Backpressure: hold y=1,s=0 while d1 waits
        do_reset();
        d0 = 1; d0_valid = 1; y_ready = 0; tick();
        chk("bp_load_yv", y_valid, 1);
        d0_valid = 0; d0 = 0; d1 = 0; d1_valid = 1; y_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_r1", d1_ready, 0);
            tick();
            chk("bp_y",  y, 1);
            chk("bp_s",  s, 0);
            chk("bp_yv", y_valid, 1);
        end
        y_ready = 1; #1;
        chk("bp_rel_r1", d1_ready, 1);
        tick();
        chk("bp_rel_s",  s, 1);
        chk("bp_rel_y",  y, 0);
        chk("bp_rel_yv", y_valid, 1);
        chk("bp_rel_c1", cnt1, 1);

        // Saturation at 2^CW-1 = 3 after 6 source-1 transfers
        do_reset();
        d1 = 1; d1_valid = 1; y_ready = 1;
        for (int i = 0; i < 6; i++) tick();
        chk("sat_c1", cnt1, 3);
        chk("sat_c0", cnt0, 0);
        tick(); tick();
        chk("sat_hold_c1", cnt1, 3);

        // Reset mid-operation restores pointer to FIRST
        do_reset();
        d0 = 1; d0_valid = 1; y_ready = 0; tick();
        d0_valid = 0; tick();
        chk("mr_pre_yv", y_valid, 1);
        chk("mr_pre_c0", cnt0, 1);
        rst = 1; tick();
        rst = 0; #1;
        chk("mr_yv", y_valid, 0);
        chk("mr_y",  y, 0);
        chk("mr_c0", cnt0, 0);
        chk("mr_c1", cnt1, 0);
        d0_valid = 1; d1_valid = 1; y_ready = 1; #1;
        chk("mr_ptr_r0", d0_ready, 1);
        chk("mr_ptr_r1", d1_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
